// File: rtl/iadc_config_sequencer_pkg.sv
// Shared constants for the iADC configuration sequencer: controller register map,
// table entry layout and sequencer state encoding.
package iadc_config_sequencer_pkg;

    // Word indices of the iADC controller slave registers
    localparam logic [7:0] REG_IADC_RESET    = 8'h00;
    localparam logic [7:0] REG_IADC_TWI_ADDR = 8'h04;
    localparam logic [7:0] REG_IADC_TWI_DATA = 8'h05;
    localparam logic [7:0] REG_IADC_TWI_TX   = 8'h06;

    localparam int ENTRY_W  = 19;
    localparam int ADDR_MSB = 18;
    localparam int ADDR_LSB = 16;
    localparam int DATA_MSB = 15;

    // The controller's busy bit is not valid until this many cycles after a TX write
    localparam logic [2:0] GAP_CYCLES = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WR_ADDR,
        S_WR_DATA,
        S_WR_TX,
        S_GAP,
        S_POLL,
        S_NEXT,
`ifdef IADC_SEQ_RESET_EN
        S_RST_WR,
        S_DCM_HOLD,
`endif
        S_FINISH
    } seq_state_e;

    function automatic logic [31:0] reg_byte_adr(input logic [31:0] base, input logic [7:0] idx);
        return base + {23'b0, idx, 1'b0};
    endfunction

endpackage

// File: rtl/iadc_config_sequencer_wbm_single_access.sv
// One-shot Wishbone master: holds cyc/stb while req_i is high until ack, then
// forces one idle cycle before the next access can start.
module wbm_single_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [15:0] dat_i,
    output logic        ack_o,
    output logic [15:0] rdata_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [1:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [15:0] wbm_dat_o,
    input  logic [15:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    logic idle_q, idle_d;
    logic active;

    always_comb begin
        active = req_i & ~idle_q;
        idle_d = active & wbm_ack_i;
    end

    always_ff @(posedge clk) begin
        if (rst) idle_q <= 1'b0;
        else     idle_q <= idle_d;
    end

    assign ack_o     = idle_d;
    assign rdata_o   = wbm_dat_i;
    assign wbm_cyc_o = active;
    assign wbm_stb_o = active;
    assign wbm_we_o  = active & we_i;
    assign wbm_sel_o = active ? 2'b11 : 2'b00;
    assign wbm_adr_o = active ? adr_i : 32'h0;
    assign wbm_dat_o = (active & we_i) ? dat_i : 16'h0;

endmodule

// File: rtl/iadc_config_sequencer.sv
// Walks a ROM table of {twi_addr, twi_data} entries and programs the iADC over Wishbone.
// Define IADC_SEQ_RESET_EN to strobe REG_IADC_RESET and hold for DCM_WAIT cycles at the end.
module iadc_config_sequencer
    import iadc_config_sequencer_pkg::*;
#(
    parameter logic [31:0] BASE_ADR     = 32'h0,
    parameter int          NUM_ENTRIES  = 8,
    parameter int          TBL_AW       = 4,
    parameter logic [15:0] POLL_TIMEOUT = 16'd4096,
    parameter logic [8:0]  DCM_WAIT     = 9'd300
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [TBL_AW-1:0] tbl_adr_o,
    input  logic [18:0]       tbl_dat_i,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [1:0]        wbm_sel_o,
    output logic [31:0]       wbm_adr_o,
    output logic [15:0]       wbm_dat_o,
    input  logic [15:0]       wbm_dat_i,
    input  logic              wbm_ack_i
);

    localparam logic [TBL_AW-1:0] LAST_IDX = TBL_AW'(NUM_ENTRIES - 1);

    seq_state_e          state_q, state_d;
    logic [TBL_AW-1:0]   idx_q, idx_d;
    logic [ENTRY_W-1:0]  entry_q, entry_d;
    logic [15:0]         poll_cnt_q, poll_cnt_d;
    logic [2:0]          gap_cnt_q, gap_cnt_d;
    logic                fetch_ph_q, fetch_ph_d;
    logic                error_q, error_d;
`ifdef IADC_SEQ_RESET_EN
    logic [8:0]          dcm_cnt_q, dcm_cnt_d;
`else
    localparam logic [8:0] dcm_wait_unused = DCM_WAIT;
`endif

    logic        req, we, ack;
    logic [7:0]  reg_idx;
    logic [15:0] wdat, rdata;
    logic        rdata_unused;

    assign rdata_unused = ^rdata[15:1];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        entry_d    = entry_q;
        poll_cnt_d = poll_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        fetch_ph_d = fetch_ph_q;
        error_d    = error_q;
`ifdef IADC_SEQ_RESET_EN
        dcm_cnt_d  = dcm_cnt_q;
`endif
        req        = 1'b0;
        we         = 1'b0;
        reg_idx    = REG_IADC_RESET;
        wdat       = 16'h0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    error_d    = 1'b0;
                    idx_d      = '0;
                    poll_cnt_d = '0;
                    fetch_ph_d = 1'b0;
                    state_d    = (NUM_ENTRIES == 0) ? S_FINISH : S_FETCH;
                end
            end
            // ROM has one cycle of read latency
            S_FETCH: begin
                fetch_ph_d = 1'b1;
                if (fetch_ph_q) begin
                    entry_d    = tbl_dat_i;
                    fetch_ph_d = 1'b0;
                    state_d    = S_WR_ADDR;
                end
            end
            S_WR_ADDR: begin
                req     = 1'b1;
                we      = 1'b1;
                reg_idx = REG_IADC_TWI_ADDR;
                wdat    = {13'b0, entry_q[ADDR_MSB:ADDR_LSB]};
                if (ack) state_d = S_WR_DATA;
            end
            S_WR_DATA: begin
                req     = 1'b1;
                we      = 1'b1;
                reg_idx = REG_IADC_TWI_DATA;
                wdat    = entry_q[DATA_MSB:0];
                if (ack) state_d = S_WR_TX;
            end
            S_WR_TX: begin
                req     = 1'b1;
                we      = 1'b1;
                reg_idx = REG_IADC_TWI_TX;
                wdat    = 16'h0001;
                if (ack) begin
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_CYCLES - 3'd1) state_d = S_POLL;
                else                                gap_cnt_d = gap_cnt_q + 3'd1;
            end
            S_POLL: begin
                req     = 1'b1;
                reg_idx = REG_IADC_TWI_TX;
                if (ack) begin
                    if (!rdata[0]) begin
                        state_d = S_NEXT;
                    end else if (poll_cnt_q >= POLL_TIMEOUT - 16'd1) begin
                        error_d = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 16'd1;
                    end
                end
            end
            // Compare before incrementing so a full 2^TBL_AW table terminates
            S_NEXT: begin
                poll_cnt_d = '0;
                if (idx_q == LAST_IDX) begin
`ifdef IADC_SEQ_RESET_EN
                    state_d = S_RST_WR;
`else
                    state_d = S_FINISH;
`endif
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
`ifdef IADC_SEQ_RESET_EN
            S_RST_WR: begin
                req     = 1'b1;
                we      = 1'b1;
                reg_idx = REG_IADC_RESET;
                wdat    = 16'h0001;
                if (ack) begin
                    dcm_cnt_d = 9'd1;
                    state_d   = S_DCM_HOLD;
                end
            end
            // done_o lands exactly DCM_WAIT cycles after the reset write ack
            S_DCM_HOLD: begin
                if ((dcm_cnt_q + 9'd1) >= DCM_WAIT) state_d = S_FINISH;
                else                                dcm_cnt_d = dcm_cnt_q + 9'd1;
            end
`endif
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            entry_q    <= '0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
            fetch_ph_q <= 1'b0;
            error_q    <= 1'b0;
`ifdef IADC_SEQ_RESET_EN
            dcm_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            entry_q    <= entry_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            fetch_ph_q <= fetch_ph_d;
            error_q    <= error_d;
`ifdef IADC_SEQ_RESET_EN
            dcm_cnt_q  <= dcm_cnt_d;
`endif
        end
    end

    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_FINISH);
    assign error_o   = error_q;
    assign tbl_adr_o = idx_q;

    wbm_single_access u_wbm (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .req_i     (req),
        .we_i      (we),
        .adr_i     (reg_byte_adr(BASE_ADR, reg_idx)),
        .dat_i     (wdat),
        .ack_o     (ack),
        .rdata_o   (rdata),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

endmodule

// File: tb/tb_iadc_config_sequencer.sv
// Bench for iadc_config_sequencer: random table contents, random slave busy counts and
// ack delays, checked against an access-list model built from the table.
module tb_iadc_config_sequencer;
    import iadc_config_sequencer_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0200;
    localparam int N    = 4;
    localparam int AW   = 2;
    localparam int PTO  = 8;
    localparam int DCMW = 12;

    localparam logic [31:0] ADR_ADR = BASE + 32'(REG_IADC_TWI_ADDR) * 2;
    localparam logic [31:0] DAT_ADR = BASE + 32'(REG_IADC_TWI_DATA) * 2;
    localparam logic [31:0] TX_ADR  = BASE + 32'(REG_IADC_TWI_TX) * 2;
    localparam logic [31:0] RST_ADR = BASE + 32'(REG_IADC_RESET) * 2;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i;
    logic          start_i;
    logic          busy_o, done_o, error_o;
    logic [AW-1:0] tbl_adr_o;
    logic [18:0]   tbl_dat_i;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [1:0]    wbm_sel_o;
    logic [31:0]   wbm_adr_o;
    logic [15:0]   wbm_dat_o;
    logic [15:0]   wbm_dat_i = 16'h0;
    logic          wbm_ack_i = 1'b0;

    always #5 wb_clk_i = ~wb_clk_i;

    iadc_config_sequencer #(
        .BASE_ADR(BASE), .NUM_ENTRIES(N), .TBL_AW(AW),
        .POLL_TIMEOUT(16'(PTO)), .DCM_WAIT(9'(DCMW))
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .tbl_adr_o(tbl_adr_o), .tbl_dat_i(tbl_dat_i),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    logic [18:0] rom [N];
    int          busy_n [N];
    bit          busy_forever = 0, hold_ack = 0, slv_clr = 1;
    int          max_dly = 0;
    int          checks = 0, failures = 0;
    int          cyc_n = 0, done_cnt = 0;

    logic [48:0] log_q [$];
    logic [48:0] exp_q [$];
    int          tx_seen = 0, polls = 0, idle_run = 0, perr = 0, dly = 0, rst_ack_cyc = 0;
    bit          in_acc = 0, seen_any = 0, last_tx = 0, bsy;
    logic [31:0] a_adr;
    logic        a_we;
    logic [15:0] a_dat;

    // Registered table ROM, cycle counter and done-pulse counter
    always @(posedge wb_clk_i) begin
        cyc_n     <= cyc_n + 1;
        tbl_dat_i <= rom[tbl_adr_o];
        if (done_o) done_cnt <= done_cnt + 1;
    end

    // Slave model: random ack delay, busy bit per entry, protocol watchdog into perr
    always @(negedge wb_clk_i) begin
        if (slv_clr) begin
            log_q.delete();
            tx_seen = 0; polls = 0; idle_run = 0; perr = 0;
            in_acc = 0; seen_any = 0; last_tx = 0;
            wbm_ack_i = 1'b0; wbm_dat_i = 16'h0;
        end else if (wbm_cyc_o && wbm_stb_o) begin
            if (!in_acc) begin
                in_acc = 1; a_adr = wbm_adr_o; a_we = wbm_we_o; a_dat = wbm_dat_o;
                dly = int'($urandom_range(max_dly));
                if (seen_any && idle_run < 1) perr++;
                if (last_tx && idle_run < 4) perr++;
                last_tx = 0; seen_any = 1;
            end else if (wbm_adr_o !== a_adr || wbm_we_o !== a_we || wbm_dat_o !== a_dat) begin
                perr++;
            end
            if (wbm_sel_o !== 2'b11) perr++;
            idle_run = 0;
            if (hold_ack || dly > 0) begin
                wbm_ack_i = 1'b0;
                if (dly > 0) dly--;
            end else begin
                wbm_ack_i = 1'b1;
                in_acc = 0;
                if (a_we) begin
                    wbm_dat_i = 16'h0;
                    log_q.push_back({1'b1, a_adr, a_dat});
                    if (a_adr == TX_ADR) begin tx_seen++; polls = 0; last_tx = 1; end
                    if (a_adr == RST_ADR) rst_ack_cyc = cyc_n;
                end else begin
                    bsy = busy_forever || (tx_seen > 0 && tx_seen <= N && polls < busy_n[tx_seen-1]);
                    polls++;
                    wbm_dat_i = {15'h0, bsy};
                    log_q.push_back({1'b0, a_adr, wbm_dat_i});
                end
            end
        end else begin
            wbm_ack_i = 1'b0;
            in_acc = 0;
            idle_run++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_slave();
        @(posedge wb_clk_i); slv_clr = 1;
        @(posedge wb_clk_i); slv_clr = 0;
        @(negedge wb_clk_i);
    endtask

    // Expected bus accesses: three writes per entry, then busy reads until the
    // slave reports idle; a timeout ends everything after PTO busy reads.
    function automatic void build_exp(input bit fbusy);
        exp_q.delete();
        for (int e = 0; e < N; e++) begin
            exp_q.push_back({1'b1, ADR_ADR, 13'b0, rom[e][18:16]});
            exp_q.push_back({1'b1, DAT_ADR, rom[e][15:0]});
            exp_q.push_back({1'b1, TX_ADR, 16'h0001});
            if (fbusy) begin
                for (int k = 0; k < PTO; k++) exp_q.push_back({1'b0, TX_ADR, 16'h0001});
                return;
            end
            for (int k = 0; k < busy_n[e]; k++) exp_q.push_back({1'b0, TX_ADR, 16'h0001});
            exp_q.push_back({1'b0, TX_ADR, 16'h0000});
        end
`ifdef IADC_SEQ_RESET_EN
        exp_q.push_back({1'b1, RST_ADR, 16'h0001});
`endif
    endfunction

    task automatic run_seq(input string tag, input bit fbusy, input bit poke_mid, input bit poke_fin);
        bit got;
        int d0, n, done_cyc;
        clr_slave();
        for (int e = 0; e < N; e++) begin
            rom[e]    = 19'($urandom);
            busy_n[e] = int'($urandom_range(4));
        end
        busy_forever = fbusy;
        build_exp(fbusy);
        d0 = done_cnt;
        start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        chk({tag, "_err_clr"}, 64'(error_o), 64'd0);
        chk({tag, "_busy_set"}, 64'(busy_o), 64'd1);
        got = 0;
        done_cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            start_i = (poke_mid && i == 20);
            @(negedge wb_clk_i);
            if (done_o) begin got = 1; done_cyc = cyc_n; break; end
        end
        start_i = poke_fin;
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        chk({tag, "_error"}, 64'(error_o), 64'(fbusy));
`ifdef IADC_SEQ_RESET_EN
        if (!fbusy) chk({tag, "_dcm_wait"}, 64'(done_cyc - rst_ack_cyc), 64'(DCMW));
`endif
        @(negedge wb_clk_i);
        start_i = 1'b0;
        chk({tag, "_busy_clr"}, 64'(busy_o), 64'd0);
        repeat (8) @(negedge wb_clk_i);
        chk({tag, "_still_idle"}, 64'({busy_o, wbm_cyc_o}), 64'd0);
        chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_proto"}, 64'(perr), 64'd0);
        chk({tag, "_n_acc"}, 64'(log_q.size()), 64'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_acc%0d", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        bit got;
        wb_rst_i = 1'b1;
        start_i  = 1'b0;
        for (int e = 0; e < N; e++) begin rom[e] = '0; busy_n[e] = 0; end
        repeat (3) @(posedge wb_clk_i);
        slv_clr = 0;
        @(negedge wb_clk_i);
        chk("rst_status", 64'({busy_o, done_o, error_o}), 64'd0);
        chk("rst_bus", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}), 64'd0);
        chk("rst_adr", 64'(wbm_adr_o), 64'd0);
        chk("rst_dat", 64'(wbm_dat_o), 64'd0);
        chk("rst_tbl_adr", 64'(tbl_adr_o), 64'd0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);

        max_dly = 5;
        run_seq("norm", 0, 1, 1);
        run_seq("tmo", 1, 0, 0);
        max_dly = 0;
        run_seq("rerun", 0, 0, 0);

        // Reset while a write is stalled waiting for ack
        clr_slave();
        hold_ack = 1;
        busy_forever = 0;
        start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge wb_clk_i);
            if (wbm_stb_o) begin got = 1; break; end
        end
        chk("rstmid_stb_seen", 64'(got), 64'd1);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        chk("rstmid_bus", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}), 64'd0);
        chk("rstmid_adr_dat", 64'({wbm_adr_o, wbm_dat_o}), 64'd0);
        chk("rstmid_status", 64'({busy_o, done_o, error_o, tbl_adr_o}), 64'd0);
        wb_rst_i = 1'b0;
        hold_ack = 0;
        repeat (6) @(negedge wb_clk_i);
        chk("rstmid_idle", 64'({busy_o, wbm_cyc_o}), 64'd0);

        max_dly = 3;
        run_seq("post", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
